// File: rtl/pw_trigger_pkg.sv
// Shared state encoding and packed-bus slicing helpers for the multi-pulse trigger sequencer.
// No logic of its own; latency and backpressure are defined by the modules that import it.
package pw_trigger_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DELAY = 2'd1,
        ST_PULSE = 2'd2
    } seq_state_t;

    localparam int PW_NUM_PULSES_DEF = 8;
    localparam int PW_IDX_W_DEF      = 3;
    localparam int PW_DELAY_W_DEF    = 20;
    localparam int PW_WIDTH_W_DEF    = 17;

    // LSB of field idx in a bus of equal-width fields packed from bit 0 upward.
    function automatic int field_lsb(input int idx, input int fld_w);
        return idx * fld_w;
    endfunction

endpackage

// File: rtl/pw_pulse_timer.sv
// Loadable down-counter with optional max(v,1)-1 clamp on load; expired is high while the count is 0.
// Load takes effect on the next edge; no backpressure, counting only gated by dec.
module pw_pulse_timer #(
    parameter int pW = 20
) (
    input  logic          fe_clk,
    input  logic          reset_n,
    input  logic          load,
    input  logic          min1,
    input  logic [pW-1:0] load_val,
    input  logic          dec,
    output logic          expired
);

    logic [pW-1:0] cnt;
    logic [pW-1:0] load_cnt;

    // With min1 set a zero-length segment still lasts one cycle, so pulses never merge.
    always_comb begin
        load_cnt = load_val;
        if (min1 && (load_val != '0)) begin
            load_cnt = load_val - pW'(1);
        end
    end

    always_ff @(posedge fe_clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_cnt;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - pW'(1);
        end
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/pw_trigger_seq.sv
// Multi-pulse trigger sequencer: match at edge k gives pulse 0 from edge k+1+d0, later pulses spaced by max(d,1)/max(w,1).
// No backpressure: matches arriving while a sequence is in flight are dropped and flagged on O_missed.
module pw_trigger_seq
    import pw_trigger_pkg::*;
#(
    parameter int pNUM_PULSES  = PW_NUM_PULSES_DEF,
    parameter int pIDX_WIDTH   = PW_IDX_W_DEF,
    parameter int pDELAY_WIDTH = PW_DELAY_W_DEF,
    parameter int pWIDTH_WIDTH = PW_WIDTH_W_DEF
) (
    input  logic                                fe_clk,
    input  logic                                reset_n,
    input  logic                                I_arm,
    input  logic                                I_enable,
    input  logic                                I_match,
    input  logic [pIDX_WIDTH:0]                 I_num_pulses,
    input  logic [pNUM_PULSES*pDELAY_WIDTH-1:0] I_delay,
    input  logic [pNUM_PULSES*pWIDTH_WIDTH-1:0] I_width,
    output logic                                O_trigger,
    output logic                                O_busy,
    output logic [pIDX_WIDTH-1:0]               O_pulse_idx,
    output logic                                O_capture_enable_pulse,
    output logic                                O_done,
    output logic                                O_missed
);

    localparam int NW = pIDX_WIDTH + 1;

    seq_state_t              state;
    seq_state_t              nxt_state;
    logic [pIDX_WIDTH-1:0]   last_idx;
    logic [pIDX_WIDTH-1:0]   next_idx;
    logic [pIDX_WIDTH-1:0]   accept_last;
    logic [NW-1:0]           n_clamped;
    logic                    in_seq;
    logic                    accept;
    logic                    abort;
    logic                    seg_start;
    logic                    seg_end;
    logic                    more;
    logic                    dly_load;
    logic                    dly_min1;
    logic                    dly_run;
    logic                    dly_exp;
    logic                    wid_run;
    logic                    wid_exp;
    logic [pDELAY_WIDTH-1:0] dly_val;
    logic [pWIDTH_WIDTH-1:0] wid_val;

    always_comb begin
        next_idx    = O_pulse_idx + pIDX_WIDTH'(1);
        n_clamped   = (I_num_pulses > NW'(pNUM_PULSES)) ? NW'(pNUM_PULSES) : I_num_pulses;
        accept_last = pIDX_WIDTH'(n_clamped - NW'(1));

        in_seq = (state != ST_IDLE);
        // O_busy still high means a sequence ended on the previous edge; that match is a miss too.
        accept = I_match & I_arm & I_enable & (I_num_pulses != '0) & ~in_seq & ~O_busy;
        abort  = in_seq & ~I_arm;

        seg_start = (state == ST_DELAY) & dly_exp & ~abort;
        seg_end   = (state == ST_PULSE) & wid_exp & ~abort;
        more      = (O_pulse_idx != last_idx);

        // Pulse 0 delay is taken as-is so d0=0 rises on the edge after the match.
        dly_load = accept | (seg_end & more);
        dly_min1 = ~accept;
        dly_val  = accept ? I_delay[field_lsb(0, pDELAY_WIDTH) +: pDELAY_WIDTH]
                          : I_delay[field_lsb(int'(next_idx), pDELAY_WIDTH) +: pDELAY_WIDTH];
        wid_val  = I_width[field_lsb(int'(O_pulse_idx), pWIDTH_WIDTH) +: pWIDTH_WIDTH];
        dly_run  = (state == ST_DELAY);
        wid_run  = (state == ST_PULSE);

        nxt_state = state;
        if (abort) begin
            nxt_state = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  if (accept)    nxt_state = ST_DELAY;
                ST_DELAY: if (seg_start) nxt_state = ST_PULSE;
                ST_PULSE: if (seg_end)   nxt_state = more ? ST_DELAY : ST_IDLE;
                default:                 nxt_state = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge fe_clk or negedge reset_n) begin
        if (!reset_n) begin
            state                  <= ST_IDLE;
            last_idx               <= '0;
            O_trigger              <= 1'b0;
            O_busy                 <= 1'b0;
            O_pulse_idx            <= '0;
            O_capture_enable_pulse <= 1'b0;
            O_done                 <= 1'b0;
            O_missed               <= 1'b0;
        end else begin
            state                  <= nxt_state;
            // Enable gates the output only; the sequence itself keeps counting.
            O_trigger              <= (nxt_state == ST_PULSE) & I_enable;
            O_busy                 <= in_seq;
            O_done                 <= seg_end & ~more;
            O_capture_enable_pulse <= seg_start & (O_pulse_idx == '0) & I_enable;

            if (accept) begin
                O_pulse_idx <= '0;
                last_idx    <= accept_last;
            end else if (seg_end && more) begin
                O_pulse_idx <= next_idx;
            end

            if (accept) begin
                O_missed <= 1'b0;
            end else if (I_match && (in_seq || O_busy)) begin
                O_missed <= 1'b1;
            end
        end
    end

    pw_pulse_timer #(.pW(pDELAY_WIDTH)) u_delay_timer (
        .fe_clk   (fe_clk),
        .reset_n  (reset_n),
        .load     (dly_load),
        .min1     (dly_min1),
        .load_val (dly_val),
        .dec      (dly_run),
        .expired  (dly_exp)
    );

    pw_pulse_timer #(.pW(pWIDTH_WIDTH)) u_width_timer (
        .fe_clk   (fe_clk),
        .reset_n  (reset_n),
        .load     (seg_start),
        .min1     (1'b1),
        .load_val (wid_val),
        .dec      (wid_run),
        .expired  (wid_exp)
    );

endmodule

// File: tb/tb_pw_trigger_seq.sv
// Scoreboard bench for pw_trigger_seq: stimulus pushes expected pulse/done events, a negedge monitor pops and compares.
// Status outputs (busy, missed, idx, reset values) are compared directly at chosen edges.
module tb_pw_trigger_seq;

    localparam int NP = 8;
    localparam int IW = 3;
    localparam int DW = 20;
    localparam int WW = 17;

    logic              fe_clk       = 1'b0;
    logic              reset_n      = 1'b0;
    logic              I_arm        = 1'b0;
    logic              I_enable     = 1'b0;
    logic              I_match      = 1'b0;
    logic [IW:0]       I_num_pulses = '0;
    logic [NP*DW-1:0]  I_delay      = '0;
    logic [NP*WW-1:0]  I_width      = '0;
    logic              O_trigger;
    logic              O_busy;
    logic [IW-1:0]     O_pulse_idx;
    logic              O_capture_enable_pulse;
    logic              O_done;
    logic              O_missed;

    typedef struct {
        int kind;   // 0 pulse, 1 done, 2 stray capture strobe
        int t;
        int len;
        int idx;
        int cap;
    } ev_t;

    ev_t expq[$];
    int  checks = 0;
    int  errors = 0;
    int  edge_n = 0;
    int  k;
    bit  prev_trig = 1'b0;
    int  cur_rise  = 0;
    int  cur_idx   = 0;
    int  cur_cap   = 0;

    pw_trigger_seq #(
        .pNUM_PULSES  (NP),
        .pIDX_WIDTH   (IW),
        .pDELAY_WIDTH (DW),
        .pWIDTH_WIDTH (WW)
    ) dut (
        .fe_clk                 (fe_clk),
        .reset_n                (reset_n),
        .I_arm                  (I_arm),
        .I_enable               (I_enable),
        .I_match                (I_match),
        .I_num_pulses           (I_num_pulses),
        .I_delay                (I_delay),
        .I_width                (I_width),
        .O_trigger              (O_trigger),
        .O_busy                 (O_busy),
        .O_pulse_idx            (O_pulse_idx),
        .O_capture_enable_pulse (O_capture_enable_pulse),
        .O_done                 (O_done),
        .O_missed               (O_missed)
    );

    always #5 fe_clk = ~fe_clk;
    always @(posedge fe_clk) edge_n <= edge_n + 1;

    function automatic ev_t mk(input int kind, input int t, input int len, input int idx, input int cap);
        ev_t e;
        e.kind = kind;
        e.t    = t;
        e.len  = len;
        e.idx  = idx;
        e.cap  = cap;
        return e;
    endfunction

    task automatic exp_pulse(input int t, input int len, input int idx, input int cap);
        expq.push_back(mk(0, t, len, idx, cap));
    endtask

    task automatic exp_done(input int t);
        expq.push_back(mk(1, t, 0, 0, 0));
    endtask

    task automatic got(input ev_t a);
        ev_t e;
        checks++;
        if (expq.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected got kind=%0d t=%0d len=%0d idx=%0d cap=%0d, nothing expected",
                     a.kind, a.t, a.len, a.idx, a.cap);
        end else begin
            e = expq.pop_front();
            if (a.kind != e.kind || a.t != e.t || a.len != e.len || a.idx != e.idx || a.cap != e.cap) begin
                errors++;
                $display("FAIL sb_event got kind=%0d t=%0d len=%0d idx=%0d cap=%0d want kind=%0d t=%0d len=%0d idx=%0d cap=%0d",
                         a.kind, a.t, a.len, a.idx, a.cap, e.kind, e.t, e.len, e.idx, e.cap);
            end
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic wait_edge(input int e);
        while (edge_n < e) @(negedge fe_clk);
    endtask

    // Returns at the negedge after the sampling edge, with edge_n == k.
    task automatic match_at(output int kk);
        @(negedge fe_clk);
        I_match = 1'b1;
        kk = edge_n + 1;
        @(negedge fe_clk);
        I_match = 1'b0;
    endtask

    task automatic set_seg(input int i, input int d, input int w);
        I_delay[i*DW +: DW] = DW'(d);
        I_width[i*WW +: WW] = WW'(w);
    endtask

    always @(negedge fe_clk) begin
        if (!reset_n) begin
            prev_trig = 1'b0;
        end else begin
            if (O_trigger && !prev_trig) begin
                cur_rise = edge_n;
                cur_idx  = int'(O_pulse_idx);
                cur_cap  = int'(O_capture_enable_pulse);
            end else if (O_capture_enable_pulse) begin
                got(mk(2, edge_n, 0, 0, 1));
            end
            if (!O_trigger && prev_trig) got(mk(0, cur_rise, edge_n - cur_rise, cur_idx, cur_cap));
            if (O_done) got(mk(1, edge_n, 0, 0, 0));
            prev_trig = O_trigger;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        chk("rst_trigger", int'(O_trigger), 0);
        chk("rst_busy",    int'(O_busy), 0);
        chk("rst_idx",     int'(O_pulse_idx), 0);
        chk("rst_cap",     int'(O_capture_enable_pulse), 0);
        chk("rst_done",    int'(O_done), 0);
        chk("rst_missed",  int'(O_missed), 0);
        #22 reset_n = 1'b1;
        I_arm    = 1'b1;
        I_enable = 1'b1;

        // Single minimal pulse: d0=0, w0=1.
        I_num_pulses = 4'd1;
        set_seg(0, 0, 1);
        match_at(k);
        exp_pulse(k + 1, 1, 0, 1);
        exp_done(k + 2);
        chk("t1_busy_k", int'(O_busy), 0);
        wait_edge(k + 1);
        chk("t1_busy_k1", int'(O_busy), 1);
        wait_edge(k + 2);
        chk("t1_busy_k2", int'(O_busy), 1);
        wait_edge(k + 3);
        chk("t1_busy_k3", int'(O_busy), 0);
        wait_edge(k + 6);

        // Three pulses with zero-length segments clamped to one cycle.
        I_num_pulses = 4'd3;
        set_seg(0, 5, 4);
        set_seg(1, 2, 1);
        set_seg(2, 0, 0);
        match_at(k);
        exp_pulse(k + 6, 4, 0, 1);
        exp_pulse(k + 12, 1, 1, 0);
        exp_pulse(k + 14, 1, 2, 0);
        exp_done(k + 15);
        wait_edge(k + 18);

        // Request above the maximum is clamped to eight pulses.
        I_num_pulses = 4'd12;
        for (int i = 0; i < NP; i++) set_seg(i, 1, 1);
        match_at(k);
        for (int i = 0; i < NP; i++) exp_pulse(k + 2 + 2 * i, 1, i, (i == 0) ? 1 : 0);
        exp_done(k + 17);
        wait_edge(k + 20);
        chk("t3_idx_end", int'(O_pulse_idx), 7);

        // Zero pulse count ignores the match.
        I_num_pulses = 4'd0;
        match_at(k);
        wait_edge(k + 3);
        chk("t4_busy_n0", int'(O_busy), 0);

        // Match during pulse 1 is dropped and flagged; flag is sticky.
        I_num_pulses = 4'd3;
        set_seg(0, 1, 3);
        set_seg(1, 1, 3);
        set_seg(2, 1, 3);
        match_at(k);
        exp_pulse(k + 2, 3, 0, 1);
        exp_pulse(k + 6, 3, 1, 0);
        exp_pulse(k + 10, 3, 2, 0);
        exp_done(k + 13);
        wait_edge(k + 6);
        I_match = 1'b1;
        @(negedge fe_clk);
        I_match = 1'b0;
        chk("t5_missed_set", int'(O_missed), 1);
        wait_edge(k + 16);
        chk("t5_missed_sticky", int'(O_missed), 1);

        // Next accepted match clears the flag; a match on the done edge sets it again.
        I_num_pulses = 4'd1;
        set_seg(0, 0, 2);
        match_at(k);
        chk("t6_missed_clr", int'(O_missed), 0);
        exp_pulse(k + 1, 2, 0, 1);
        exp_done(k + 3);
        wait_edge(k + 2);
        I_match = 1'b1;
        @(negedge fe_clk);
        I_match = 1'b0;
        chk("t6_missed_done", int'(O_missed), 1);
        wait_edge(k + 8);

        // Enable drop cuts the pulse but the sequence still completes.
        set_seg(0, 0, 6);
        match_at(k);
        exp_pulse(k + 1, 2, 0, 1);
        exp_done(k + 7);
        wait_edge(k + 2);
        I_enable = 1'b0;
        wait_edge(k + 5);
        chk("t7_busy_noen", int'(O_busy), 1);
        chk("t7_trig_noen", int'(O_trigger), 0);
        wait_edge(k + 9);
        I_enable = 1'b1;
        wait_edge(k + 11);

        // Disarm during the pulse 2 delay aborts without done; re-arm restarts at idx 0.
        I_num_pulses = 4'd3;
        set_seg(0, 1, 2);
        set_seg(1, 4, 2);
        set_seg(2, 6, 2);
        match_at(k);
        exp_pulse(k + 2, 2, 0, 1);
        exp_pulse(k + 8, 2, 1, 0);
        wait_edge(k + 11);
        I_arm = 1'b0;
        wait_edge(k + 13);
        chk("t8_busy_abort", int'(O_busy), 0);
        chk("t8_trig_abort", int'(O_trigger), 0);
        wait_edge(k + 20);
        chk("t8_trig_late", int'(O_trigger), 0);
        I_arm = 1'b1;
        match_at(k);
        exp_pulse(k + 2, 2, 0, 1);
        exp_pulse(k + 8, 2, 1, 0);
        exp_pulse(k + 16, 2, 2, 0);
        exp_done(k + 18);
        wait_edge(k + 22);

        // Asynchronous reset in the middle of pulse 1.
        I_num_pulses = 4'd2;
        set_seg(0, 0, 1);
        set_seg(1, 0, 50);
        match_at(k);
        exp_pulse(k + 1, 1, 0, 1);
        wait_edge(k + 4);
        I_match = 1'b1;
        @(negedge fe_clk);
        I_match = 1'b0;
        chk("t9_pre_missed", int'(O_missed), 1);
        chk("t9_pre_trig",   int'(O_trigger), 1);
        chk("t9_pre_idx",    int'(O_pulse_idx), 1);
        @(posedge fe_clk);
        #2 reset_n = 1'b0;
        #1;
        chk("t9_rst_trig",   int'(O_trigger), 0);
        chk("t9_rst_busy",   int'(O_busy), 0);
        chk("t9_rst_idx",    int'(O_pulse_idx), 0);
        chk("t9_rst_missed", int'(O_missed), 0);
        chk("t9_rst_done",   int'(O_done), 0);
        chk("t9_rst_cap",    int'(O_capture_enable_pulse), 0);
        #12 reset_n = 1'b1;
        repeat (5) @(negedge fe_clk);

        chk("sb_drain", expq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
